msf_time_keeper: RTL and testbench
==================================

// Module: msf_time_keeper
// PURPOSE
//   Parametrised successor to the MSF top-level time path. Holds a running HH:MM:SS BCD
//     time, advanced by the decoder's per-second strobe, and loads decoded frames.
//   Adds frame-agreement lock qualification, holdover tracking and a registered
//     digit/status mux, so the 8-bit pad budget can show every digit.
//   Sits between time_date_decoder/decoder and io_out.
// PARAMETERS
//   CLK_HZ        1000  clk_i cycles per second; sizes the free-run divider
//   LOCK_FRAMES   2     consecutive agreeing valid frames required to assert locked_o (1..7)
//   HOLDOVER_MIN  15    minutes without a valid frame before LOCKED -> HOLDOVER (1..63)
// PORTS
//   clk_i        in   1  clock
//   rst_i        in   1  reset, asynchronous, active-high
//   sec_tick_i   in   1  one-cycle strobe per received second (decoder bits_valid)
//   load_i       in   1  one-cycle strobe: decoded frame valid (time_date_decoder valid_o)
//   hour_h_i     in   2  BCD hour tens
//   hour_l_i     in   4  BCD hour units
//   minute_h_i   in   3  BCD minute tens
//   minute_l_i   in   4  BCD minute units
//   sel_i        in   3  digit select
//   digit_o      out  4  selected digit/status, registered
//   time_valid_o out  1  at least one valid frame loaded since reset
//   locked_o     out  1  state == LOCKED
//   holdover_o   out  1  state == HOLDOVER
// BEHAVIOUR
//   Reset: time 00:00:00, match_cnt 0, min_since_load 0, divider 0, state UNSYNC,
//     all outputs 0.
//   tick = sec_tick_i | int_tick. Tick: sec+1; 59->00 carries to min; min 59->00 carries
//     to hour; 23:59:59 -> 00:00:00. BCD units wrap 9->0, tens carry.
//   Frame check on load_i: hour <= 23, minute <= 59, every digit <= 9.
//     Invalid: time untouched, match_cnt <= 0, state unchanged.
//   Valid load: HH:MM <= inputs, sec <= 00, min_since_load <= 0, time_valid_o <= 1.
//     Load beats tick in the same cycle: no increment.
//   Agreement: compare the input HH:MM with predicted HH:MM, i.e. the tick-path next
//     state if tick is high this cycle, else the current value.
//     Equal: match_cnt <= min(match_cnt+1, LOCK_FRAMES). Differ: match_cnt <= 1.
//   min_since_load increments on every minute carry and saturates at 63.
//   FSM (registered; flags follow state one cycle after the event):
//     UNSYNC   -> ACQUIRE on valid load
//     ACQUIRE  -> LOCKED when match_cnt reaches LOCK_FRAMES
//     LOCKED   -> HOLDOVER when min_since_load == HOLDOVER_MIN; a mismatching valid
//                 load -> ACQUIRE
//     HOLDOVER -> ACQUIRE on valid load; time keeps counting throughout
//   digit_o (registered, 1-cycle latency from sel_i/time change):
//     sel 0 sec_l, 1 sec_h, 2 min_l, 3 min_h, 4 hour_l, 5 hour_h,
//     sel 6 {1'b0, holdover_o, locked_o, time_valid_o}, sel 7 4'hF.
//   Reset asserted mid-operation clears everything at once, with no pending strobes kept.
// CONFIGURATION
//   MSF_KEEPER_FREERUN_EN defined: divider counts 0..CLK_HZ-1.
//     sec_tick_i clears the divider to 0.
//     Reaching CLK_HZ-1 without sec_tick_i pulses int_tick for 1 cycle and wraps to 0,
//     so time runs through signal loss.
//   MSF_KEEPER_FREERUN_EN undefined: no divider, int_tick == 0, and time advances
//     only on sec_tick_i.
// TESTING
//   Reset, sel 0..7 -> digit_o 0,0,0,0,0,0,0,F; all flags 0.
//   Load 12:34, then 59 ticks, 1 tick -> digit_o sel 3..0 reads 3,5,0,0 (12:35:00).
//   Preset 23:59:59, tick -> 00:00:00 with no spurious carry.
//   Load 10:00, 60 ticks, load 10:01 -> locked_o=1 the cycle after; later load
//     10:05 -> locked_o=0, state ACQUIRE.
//   Load 24:00 or minute_l=A -> ignored, time unchanged, match_cnt 0.
//   Load and tick in the same cycle -> sec=00, no increment.
//   LOCKED, 15 minute carries with no load -> holdover_o=1, sel 6 = 4'b0101.
//   FREERUN_EN, CLK_HZ=1000, no sec_tick_i for 1000 cycles -> sec+1.

Source files
------------

// File: rtl/msf_time_keeper.sv
// msf_time_keeper: BCD HH:MM:SS time keeper with frame-agreement lock, holdover and digit mux.
// Optional free-run second divider enabled by defining MSF_KEEPER_FREERUN_EN.
module msf_time_keeper #(
    parameter int CLK_HZ       = 1000,
    parameter int LOCK_FRAMES  = 2,
    parameter int HOLDOVER_MIN = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sec_tick_i,
    input  logic       load_i,
    input  logic [1:0] hour_h_i,
    input  logic [3:0] hour_l_i,
    input  logic [2:0] minute_h_i,
    input  logic [3:0] minute_l_i,
    input  logic [2:0] sel_i,
    output logic [3:0] digit_o,
    output logic       time_valid_o,
    output logic       locked_o,
    output logic       holdover_o
);
    typedef enum logic [1:0] {UNSYNC, ACQUIRE, LOCKED, HOLDOVER} state_t;
    state_t state, state_n;
    logic [3:0] sec_l, min_l, hour_l, nx_sec_l, nx_min_l, nx_hour_l;
    logic [2:0] sec_h, min_h, nx_sec_h, nx_min_h;
    logic [1:0] hour_h, nx_hour_h;
    logic [2:0] match_cnt, match_n;
    logic [5:0] min_since_load;
    logic       int_tick, tick, frame_ok, vload, agree, sec59, min59, hr23;
    logic [12:0] pred_hm;
    logic [3:0] dig [8];

`ifdef MSF_KEEPER_FREERUN_EN
    localparam int DW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    logic [DW-1:0] div;
    assign int_tick = !sec_tick_i && div == DW'(CLK_HZ - 1);
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) div <= '0;
        else       div <= (sec_tick_i || int_tick) ? '0 : div + 1'b1;
`else
    assign int_tick = 1'b0;
`endif

    assign tick     = sec_tick_i | int_tick;
    assign frame_ok = hour_l_i <= 4'd9 && minute_l_i <= 4'd9 && minute_h_i <= 3'd5 &&
                      (hour_h_i < 2'd2 || (hour_h_i == 2'd2 && hour_l_i <= 4'd3));
    assign vload    = load_i & frame_ok;
    assign sec59    = sec_l == 4'd9 && sec_h == 3'd5;
    assign min59    = min_l == 4'd9 && min_h == 3'd5;
    assign hr23     = hour_h == 2'd2 && hour_l == 4'd3;

    // Tick-path successor of the current time, used both for advancing and for prediction
    always_comb begin
        nx_sec_l  = sec_l == 4'd9 ? 4'd0 : sec_l + 4'd1;
        nx_sec_h  = sec_l == 4'd9 ? (sec_h == 3'd5 ? 3'd0 : sec_h + 3'd1) : sec_h;
        nx_min_l  = sec59 ? (min_l == 4'd9 ? 4'd0 : min_l + 4'd1) : min_l;
        nx_min_h  = sec59 && min_l == 4'd9 ? (min_h == 3'd5 ? 3'd0 : min_h + 3'd1) : min_h;
        nx_hour_l = sec59 && min59 ? ((hr23 || hour_l == 4'd9) ? 4'd0 : hour_l + 4'd1) : hour_l;
        nx_hour_h = sec59 && min59 ? (hr23 ? 2'd0 : hour_l == 4'd9 ? hour_h + 2'd1 : hour_h) : hour_h;
        pred_hm   = tick ? {nx_hour_h, nx_hour_l, nx_min_h, nx_min_l} : {hour_h, hour_l, min_h, min_l};
        agree     = {hour_h_i, hour_l_i, minute_h_i, minute_l_i} == pred_hm;
        match_n   = !load_i ? match_cnt : !frame_ok ? 3'd0 : !agree ? 3'd1 :
                    match_cnt >= 3'(LOCK_FRAMES) ? 3'(LOCK_FRAMES) : match_cnt + 3'd1;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            UNSYNC:   state_n = vload ? ACQUIRE : UNSYNC;
            ACQUIRE:  state_n = match_n == 3'(LOCK_FRAMES) ? LOCKED : ACQUIRE;
            LOCKED:   state_n = (vload && !agree) ? ACQUIRE :
                                (!vload && min_since_load == 6'(HOLDOVER_MIN)) ? HOLDOVER : LOCKED;
            HOLDOVER: state_n = vload ? ACQUIRE : HOLDOVER;
            default:  state_n = UNSYNC;
        endcase
    end

    assign locked_o   = state == LOCKED;
    assign holdover_o = state == HOLDOVER;
    assign dig[0] = sec_l;
    assign dig[1] = {1'b0, sec_h};
    assign dig[2] = min_l;
    assign dig[3] = {1'b0, min_h};
    assign dig[4] = hour_l;
    assign dig[5] = {2'b0, hour_h};
    assign dig[6] = {1'b0, holdover_o, locked_o, time_valid_o};
    assign dig[7] = 4'hF;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {sec_l, sec_h, min_l, min_h, hour_l, hour_h} <= '0;
            match_cnt      <= '0;
            min_since_load <= '0;
            time_valid_o   <= 1'b0;
            digit_o        <= '0;
            state          <= UNSYNC;
        end else begin
            if (vload) begin
                {hour_h, hour_l, min_h, min_l} <= {hour_h_i, hour_l_i, minute_h_i, minute_l_i};
                {sec_h, sec_l} <= '0;
            end else if (tick) begin
                {sec_l, sec_h, min_l, min_h} <= {nx_sec_l, nx_sec_h, nx_min_l, nx_min_h};
                {hour_l, hour_h} <= {nx_hour_l, nx_hour_h};
            end
            min_since_load <= vload ? 6'd0 :
                              (tick && sec59 && min_since_load != 6'd63) ? min_since_load + 6'd1 : min_since_load;
            match_cnt    <= match_n;
            time_valid_o <= time_valid_o | vload;
            digit_o      <= dig[sel_i];
            state        <= state_n;
        end
    end
endmodule

// File: tb/tb_msf_time_keeper.sv
// tb_msf_time_keeper: directed scoreboard bench for msf_time_keeper.
module tb_msf_time_keeper;
    logic       clk_i = 0, rst_i = 1, sec_tick_i = 0, load_i = 0;
    logic [1:0] hour_h_i = 0;
    logic [3:0] hour_l_i = 0, minute_l_i = 0;
    logic [2:0] minute_h_i = 0, sel_i = 0;
    logic [3:0] digit_o;
    logic       time_valid_o, locked_o, holdover_o;

    typedef struct {string tag; logic [3:0] val;} exp_t;
    exp_t sb[$];
    int errors = 0, checks = 0;

    msf_time_keeper dut (
        .clk_i(clk_i), .rst_i(rst_i), .sec_tick_i(sec_tick_i), .load_i(load_i),
        .hour_h_i(hour_h_i), .hour_l_i(hour_l_i), .minute_h_i(minute_h_i),
        .minute_l_i(minute_l_i), .sel_i(sel_i), .digit_o(digit_o),
        .time_valid_o(time_valid_o), .locked_o(locked_o), .holdover_o(holdover_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic push(string tag, logic [3:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(logic [3:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic dig(int s, logic [3:0] v, string tag);
        push(tag, v);
        sel_i = 3'(s);
        step();
        check(digit_o);
    endtask

    task automatic flags(logic tv, logic lk, logic ho, string tag);
        push(tag, {1'b0, ho, lk, tv});
        check({1'b0, holdover_o, locked_o, time_valid_o});
    endtask

    task automatic tick(int n);
        repeat (n) begin
            sec_tick_i = 1;
            step();
        end
        sec_tick_i = 0;
    endtask

    task automatic load(logic [1:0] hh, logic [3:0] hl, logic [2:0] mh, logic [3:0] ml, logic t = 0);
        {hour_h_i, hour_l_i, minute_h_i, minute_l_i} = {hh, hl, mh, ml};
        load_i = 1;
        sec_tick_i = t;
        step();
        load_i = 0;
        sec_tick_i = 0;
    endtask

    task automatic time_is(logic [3:0] hh, logic [3:0] hl, logic [3:0] mh, logic [3:0] ml,
                           logic [3:0] sh, logic [3:0] sl, string tag);
        dig(5, hh, {tag, "_hh"});
        dig(4, hl, {tag, "_hl"});
        dig(3, mh, {tag, "_mh"});
        dig(2, ml, {tag, "_ml"});
        dig(1, sh, {tag, "_sh"});
        dig(0, sl, {tag, "_sl"});
    endtask

    initial begin
        repeat (3) step();
        rst_i = 0;
        flags(0, 0, 0, "rst_flags");
        for (int s = 0; s < 6; s++) dig(s, 4'h0, $sformatf("rst_sel%0d", s));
        dig(6, 4'h0, "rst_sel6");
        dig(7, 4'hF, "rst_sel7");

        load(1, 2, 3, 4);
        flags(1, 0, 0, "first_load");
        tick(59);
        tick(1);
        dig(3, 4'd3, "carry_mh");
        dig(2, 4'd5, "carry_ml");
        dig(1, 4'd0, "carry_sh");
        dig(0, 4'd0, "carry_sl");

        load(2, 3, 5, 9);
        tick(59);
        time_is(2, 3, 5, 9, 5, 9, "pre_wrap");
        tick(1);
        time_is(0, 0, 0, 0, 0, 0, "day_wrap");
        flags(1, 0, 0, "wrap_flags");

        load(1, 0, 0, 0);
        tick(60);
        load(1, 0, 0, 1);
        flags(1, 1, 0, "lock");
        dig(6, 4'b0011, "lock_sel6");
        load(1, 0, 0, 5);
        flags(1, 0, 0, "unlock");
        time_is(1, 0, 0, 5, 0, 0, "t1005");

        load(2, 4, 0, 0);
        time_is(1, 0, 0, 5, 0, 0, "hr24_ignored");
        load(1, 0, 0, 5);
        flags(1, 0, 0, "hr24_clears_match");
        load(1, 0, 0, 4'hA);
        time_is(1, 0, 0, 5, 0, 0, "mlA_ignored");
        load(1, 0, 0, 5);
        flags(1, 0, 0, "mlA_clears_match");
        load(1, 0, 0, 5);
        flags(1, 1, 0, "relock");

        tick(5);
        load(1, 0, 0, 5, 1);
        time_is(1, 0, 0, 5, 0, 0, "load_beats_tick");
        flags(1, 1, 0, "load_tick_agree");

        tick(840);
        step();
        flags(1, 1, 0, "pre_holdover");
        tick(60);
        step();
        flags(1, 0, 1, "holdover");
        dig(6, 4'b0101, "holdover_sel6");
        time_is(1, 0, 2, 0, 0, 0, "holdover_time");

        load(1, 0, 2, 0);
        flags(1, 0, 0, "hold_to_acq");
        step();
        flags(1, 1, 0, "acq_to_lock");

        tick(3);
        #2 rst_i = 1;
        #1;
        flags(0, 0, 0, "async_rst");
        step();
        rst_i = 0;
        time_is(0, 0, 0, 0, 0, 0, "rst_time");
        dig(6, 4'h0, "rst_status");

`ifdef MSF_KEEPER_FREERUN_EN
        rst_i = 1;
        step();
        rst_i = 0;
        repeat (999) step();
        dig(0, 4'd0, "freerun_999");
        dig(0, 4'd1, "freerun_1000");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
